ternary_mem_reader: RTL

Sequential read-back engine for the ternary system: after the CPU halts, it reads a range of 9-trit words out of data memory and streams each word to the bench/host as a signed binary integer over a valid/ready handshake. It is the read-side counterpart of the program loader. The loader writes ternary words into memory; this block reads them back and decodes them, converting balanced ternary to binary one trit per cycle. It shares the memory port with the loader and CPU through the system's existing mux and owns that port only while busy.

---
 rtl/ternary_mem_reader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ternary_mem_reader.sv
// Post-halt read-back engine: fetches a range of 9-trit words from data memory
// and streams each one out as a signed binary integer over valid/ready.
module ternary_mem_reader #(
  parameter int unsigned WORDS_W = 9,
  localparam int unsigned ADDR_W = 18,
  localparam int unsigned DATA_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [WORDS_W-1:0]       word_count,
  output logic                     mem_read,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [ADDR_W-1:0]        mem_read_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [WORDS_W-1:0]       out_index,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int unsigned TRITS = 9;
  localparam int unsigned CNT_W = 4;
  localparam logic [1:0] T_ZERO = 2'b00;
  localparam logic [1:0] T_POS  = 2'b01;
  localparam logic [1:0] T_NEG  = 2'b10;
  localparam logic [1:0] T_BAD  = 2'b11;

  typedef enum logic [2:0] {IDLE, READ, WAIT, CONVERT, OUTPUT, FINISH} state_t;

  state_t                     state, state_next;
  logic [ADDR_W-1:0]          addr_reg, addr_d, shift_reg;
  logic [WORDS_W-1:0]         remaining, index;
  logic signed [DATA_W-1:0]   acc, acc_step, trit_val;
  logic [CNT_W-1:0]           trit_cnt;
  logic                       launch_c, invalid_c;
  logic [1:0]                 trit_code;

  // Balanced-ternary +1; an all-positive word rolls over to all-negative.
  function automatic logic [ADDR_W-1:0] ternary_inc(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    logic              carry;
    r     = a;
    carry = 1'b1;
    for (int i = 0; i < int'(TRITS); i++) begin
      if (carry) begin
        case (a[2*i +: 2])
          T_POS:   r[2*i +: 2] = T_NEG;
          T_NEG:   begin r[2*i +: 2] = T_ZERO; carry = 1'b0; end
          default: begin r[2*i +: 2] = T_POS;  carry = 1'b0; end
        endcase
      end
    end
    return r;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state, trit decode and next-address selection.
  always_comb begin
    state_next = state;
    launch_c   = 1'b0;
    addr_d     = addr_reg;
    trit_code  = shift_reg[ADDR_W-1 -: 2];
    invalid_c  = (trit_code == T_BAD);
    case (trit_code)
      T_POS:   trit_val = DATA_W'(1);
      T_NEG:   trit_val = -DATA_W'(1);
      default: trit_val = '0;
    endcase
    acc_step = (acc <<< 1) + acc + trit_val;
    case (state)
      IDLE: begin
        addr_d = base_addr;
        if (start && !busy) begin
          launch_c   = 1'b1;
          state_next = (word_count == '0) ? FINISH : READ;
        end
      end
      READ:    state_next = WAIT;
      WAIT:    state_next = CONVERT;
      CONVERT: if (trit_cnt == '0) state_next = OUTPUT;
      OUTPUT: begin
        addr_d = ternary_inc(addr_reg);
        if (out_ready) state_next = (remaining > WORDS_W'(1)) ? READ : FINISH;
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs; busy stays up one cycle past done.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_read  <= 1'b0;
      mem_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      addr_reg  <= '0;
      remaining <= '0;
      index     <= '0;
      shift_reg <= '0;
      acc       <= '0;
      trit_cnt  <= '0;
    end else begin
      mem_read  <= (state_next == READ);
      out_valid <= (state_next == OUTPUT);
      done      <= (state_next == FINISH);
      busy      <= (state != IDLE) || (state_next != IDLE);
      if (state_next == READ) mem_addr <= addr_d;
      case (state)
        IDLE: begin
          if (launch_c) begin
            addr_reg  <= base_addr;
            remaining <= word_count;
            index     <= '0;
            error     <= 1'b0;
          end
        end
        WAIT: begin
          shift_reg <= mem_read_data;
          acc       <= '0;
          trit_cnt  <= CNT_W'(TRITS - 1);
        end
        CONVERT: begin
          acc       <= acc_step;
          shift_reg <= {shift_reg[ADDR_W-3:0], 2'b00};
          trit_cnt  <= trit_cnt - CNT_W'(1);
          if (invalid_c) error <= 1'b1;
          if (trit_cnt == '0) begin
            out_data  <= acc_step;
            out_index <= index;
            out_last  <= (remaining == WORDS_W'(1));
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            addr_reg  <= addr_d;
            remaining <= remaining - WORDS_W'(1);
            index     <= index + WORDS_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
